// File: rtl/vga_menu_pkg.sv
// Shared constants for the VGA menu grid: button bit positions, direction codes
// and the index-width helper.
package vga_menu_pkg;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_A     = 4;
  localparam int unsigned BTN_B     = 5;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/menu_nav_fsm.sv
// Menu navigation: button edge detect, pending flags, auto-repeat counter and
// the hovered/committed cell registers, all updated only on frame boundaries.
module menu_nav_fsm
  import vga_menu_pkg::*;
#(
  parameter int unsigned ROWS           = 2,
  parameter int unsigned COLS           = 2,
  parameter int unsigned WRAP           = 1,
  parameter int unsigned REPEAT_DELAY   = 20,
  parameter int unsigned REPEAT_RATE    = 6,
  parameter int unsigned DEFAULT_CHOICE = 0,
  parameter int unsigned IDX_W          = idx_width(ROWS * COLS)
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic             screenEnd,
  input  logic [7:0]       buttons,
  input  logic             fsm_en,
  output logic [IDX_W-1:0] sel,
  output logic [IDX_W-1:0] chc,
  output logic             chc_valid
);

  localparam int unsigned RW = idx_width(ROWS);
  localparam int unsigned CW = idx_width(COLS);
  localparam logic [RW-1:0] RMAX  = RW'(ROWS - 1);
  localparam logic [CW-1:0] CMAX  = CW'(COLS - 1);
  localparam logic [RW-1:0] DEF_R = RW'(DEFAULT_CHOICE / COLS);
  localparam logic [CW-1:0] DEF_C = CW'(DEFAULT_CHOICE % COLS);

  logic [5:0]    btn_q, btn_prev_q, rise;
  logic [3:0]    held_q;
  logic [5:0]    cnt_q, cnt_d;
  logic          rep_q, rep_d;
  dir_e          dir_q, dir_d, held_dir, mv_dir;
  logic          dir_vld_q, dir_vld_d, conf_q, conf_d, canc_q, canc_d;
  logic          chc_valid_q, chc_valid_d, inject, mv_vld;
  logic [RW-1:0] sel_r_q, sel_r_d, chc_r_q, chc_r_d;
  logic [CW-1:0] sel_c_q, sel_c_d, chc_c_q, chc_c_d;
  logic          unused_btn;

  assign unused_btn = ^buttons[7:6];
  assign rise       = btn_q & ~btn_prev_q;

  always_comb begin
    cnt_d       = cnt_q;
    rep_d       = rep_q;
    dir_d       = dir_q;
    dir_vld_d   = dir_vld_q;
    conf_d      = conf_q;
    canc_d      = canc_q;
    sel_r_d     = sel_r_q;
    sel_c_d     = sel_c_q;
    chc_r_d     = chc_r_q;
    chc_c_d     = chc_c_q;
    chc_valid_d = 1'b0;
    inject      = 1'b0;
    held_dir    = DIR_UP;
    for (int i = 0; i < 4; i++) begin
      if (btn_q[i]) held_dir = dir_e'(2'(i));
    end

    // Repeat counter only runs while one unchanged direction is held.
    if (!fsm_en || !$onehot(btn_q[3:0]) || (btn_q[3:0] != held_q)) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (screenEnd) begin
      if (32'(cnt_q) + 32'd1 == (rep_q ? REPEAT_RATE : REPEAT_DELAY)) begin
        inject = 1'b1;
        cnt_d  = '0;
        rep_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end

    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        dir_d     = dir_e'(2'(i));
        dir_vld_d = 1'b1;
      end
    end
    if (rise[BTN_A]) conf_d = 1'b1;
    if (rise[BTN_B]) canc_d = 1'b1;

    mv_vld = dir_vld_q | inject;
    mv_dir = inject ? held_dir : dir_q;

    if (!fsm_en) begin
      dir_vld_d = 1'b0;
      conf_d    = 1'b0;
      canc_d    = 1'b0;
    end else if (screenEnd) begin
      if (canc_q) begin
        sel_r_d = chc_r_q;
        sel_c_d = chc_c_q;
      end else if (conf_q) begin
        chc_r_d     = sel_r_q;
        chc_c_d     = sel_c_q;
        chc_valid_d = 1'b1;
      end else if (mv_vld) begin
        unique case (mv_dir)
          DIR_RIGHT: sel_c_d = (sel_c_q == CMAX) ? ((WRAP != 0) ? '0 : sel_c_q)
                                                 : sel_c_q + CW'(1);
          DIR_LEFT:  sel_c_d = (sel_c_q == '0) ? ((WRAP != 0) ? CMAX : sel_c_q)
                                               : sel_c_q - CW'(1);
          DIR_DOWN:  sel_r_d = (sel_r_q == RMAX) ? ((WRAP != 0) ? '0 : sel_r_q)
                                                 : sel_r_q + RW'(1);
          DIR_UP:    sel_r_d = (sel_r_q == '0) ? ((WRAP != 0) ? RMAX : sel_r_q)
                                               : sel_r_q - RW'(1);
        endcase
      end
      dir_vld_d = 1'b0;
      conf_d    = 1'b0;
      canc_d    = 1'b0;
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      btn_q       <= '0;
      btn_prev_q  <= '0;
      held_q      <= '0;
      cnt_q       <= '0;
      rep_q       <= 1'b0;
      dir_q       <= DIR_UP;
      dir_vld_q   <= 1'b0;
      conf_q      <= 1'b0;
      canc_q      <= 1'b0;
      chc_valid_q <= 1'b0;
      sel_r_q     <= DEF_R;
      sel_c_q     <= DEF_C;
      chc_r_q     <= DEF_R;
      chc_c_q     <= DEF_C;
    end else begin
      btn_q       <= buttons[5:0];
      btn_prev_q  <= btn_q;
      held_q      <= btn_q[3:0];
      cnt_q       <= cnt_d;
      rep_q       <= rep_d;
      dir_q       <= dir_d;
      dir_vld_q   <= dir_vld_d;
      conf_q      <= conf_d;
      canc_q      <= canc_d;
      chc_valid_q <= chc_valid_d;
      sel_r_q     <= sel_r_d;
      sel_c_q     <= sel_c_d;
      chc_r_q     <= chc_r_d;
      chc_c_q     <= chc_c_d;
    end
  end

  assign sel       = IDX_W'(32'(sel_r_q) * COLS + 32'(sel_c_q));
  assign chc       = IDX_W'(32'(chc_r_q) * COLS + 32'(chc_c_q));
  assign chc_valid = chc_valid_q;

endmodule

// File: rtl/vga_menu_grid.sv
// R x C menu grid overlay: two-stage pixel path drawing a selection bar under the
// hovered cell and a marker on the committed cell.
module vga_menu_grid
  import vga_menu_pkg::*;
#(
  parameter int unsigned ROWS           = 2,
  parameter int unsigned COLS           = 2,
  parameter int unsigned SCALE_SHIFT    = 2,
  parameter int unsigned ORIGIN_X       = 4,
  parameter int unsigned ORIGIN_Y       = 11,
  parameter int unsigned CELL_W         = 71,
  parameter int unsigned CELL_H         = 39,
  parameter int unsigned GAP_X          = 10,
  parameter int unsigned GAP_Y          = 0,
  parameter int unsigned BAR_H          = 2,
  parameter int unsigned MARK           = 3,
  parameter int unsigned WRAP           = 1,
  parameter int unsigned REPEAT_DELAY   = 20,
  parameter int unsigned REPEAT_RATE    = 6,
  parameter int unsigned DEFAULT_CHOICE = 0,
  localparam int unsigned IDX_W         = idx_width(ROWS * COLS)
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic [9:0]       x,
  input  logic [8:0]       y,
  input  logic             active,
  input  logic             screenEnd,
  input  logic [7:0]       buttons,
  input  logic             fsm_en,
  input  logic [11:0]      color0,
  input  logic [11:0]      color1,
  output logic [3:0]       VGA_R,
  output logic [3:0]       VGA_G,
  output logic [3:0]       VGA_B,
  output logic [IDX_W-1:0] sel,
  output logic [IDX_W-1:0] chc,
  output logic             chc_valid
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned NP = 1 << IDX_W;

  logic [9:0]    x_adj;
  logic [8:0]    y_adj;
  logic [NP-1:0] bar_d, mark_d, bar_q, mark_q;
  logic          act_q;
  logic [11:0]   rgb_q;

  menu_nav_fsm #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .WRAP          (WRAP),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_RATE   (REPEAT_RATE),
    .DEFAULT_CHOICE(DEFAULT_CHOICE),
    .IDX_W         (IDX_W)
  ) u_nav (
    .clk25    (clk25),
    .reset    (reset),
    .screenEnd(screenEnd),
    .buttons  (buttons),
    .fsm_en   (fsm_en),
    .sel      (sel),
    .chc      (chc),
    .chc_valid(chc_valid)
  );

  assign x_adj = x >> SCALE_SHIFT;
  assign y_adj = y >> SCALE_SHIFT;

  // Hit vectors are padded to a power of two so sel/chc index them directly.
  for (genvar g = 0; g < NP; g++) begin : g_cell
    if (g < N) begin : g_hit
      localparam int unsigned L = ORIGIN_X + (g % COLS) * (CELL_W + GAP_X);
      localparam int unsigned T = ORIGIN_Y + (g / COLS) * (CELL_H + GAP_Y);
      assign bar_d[g]  = (32'(x_adj) >= L) && (32'(x_adj) < L + CELL_W) &&
                         (32'(y_adj) >= T + CELL_H - BAR_H) && (32'(y_adj) < T + CELL_H);
      assign mark_d[g] = (32'(x_adj) >= L + CELL_W - MARK) && (32'(x_adj) < L + CELL_W) &&
                         (32'(y_adj) >= T) && (32'(y_adj) < T + MARK);
    end else begin : g_pad
      assign bar_d[g]  = 1'b0;
      assign mark_d[g] = 1'b0;
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      bar_q  <= '0;
      mark_q <= '0;
      act_q  <= 1'b0;
      rgb_q  <= '0;
    end else begin
      bar_q  <= bar_d;
      mark_q <= mark_d;
      act_q  <= active;
      if (!act_q) begin
        rgb_q <= '0;
      end else if (bar_q[sel] || mark_q[chc]) begin
        rgb_q <= color1;
      end else begin
        rgb_q <= color0;
      end
    end
  end

  assign VGA_R = rgb_q[11:8];
  assign VGA_G = rgb_q[7:4];
  assign VGA_B = rgb_q[3:0];

endmodule

// File: tb/tb_vga_menu_grid.sv
// Directed bench for vga_menu_grid: three instances (2x2 wrap, 3x3 clamp, 1x8)
// share stimulus; each scenario task resets and checks the instance it targets.
module tb_vga_menu_grid;

  localparam logic [11:0] C0 = 12'h123;
  localparam logic [11:0] C1 = 12'hABC;
  localparam int BTN_UP = 0, BTN_DOWN = 1, BTN_LEFT = 2, BTN_RIGHT = 3, BTN_A = 4, BTN_B = 5;

  logic        clk25 = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x = '0;
  logic [8:0]  y = '0;
  logic        active = 1'b0;
  logic        screenEnd = 1'b0;
  logic [7:0]  buttons = '0;
  logic        fsm_en = 1'b1;
  logic [11:0] color0 = C0;
  logic [11:0] color1 = C1;

  logic [3:0] ra, ga, ba, rb, gb, bb, rc, gc, bc;
  logic [1:0] sel_a, chc_a;
  logic [3:0] sel_b, chc_b;
  logic [2:0] sel_c, chc_c;
  logic       cv_a, cv_b, cv_c;
  logic [11:0] rgb_a;

  int n_vec = 0;
  int n_miss = 0;

  assign rgb_a = {ra, ga, ba};

  always #20 clk25 = ~clk25;

  vga_menu_grid dut_a (
    .clk25(clk25), .reset(reset), .x(x), .y(y), .active(active), .screenEnd(screenEnd),
    .buttons(buttons), .fsm_en(fsm_en), .color0(color0), .color1(color1),
    .VGA_R(ra), .VGA_G(ga), .VGA_B(ba), .sel(sel_a), .chc(chc_a), .chc_valid(cv_a)
  );

  vga_menu_grid #(.ROWS(3), .COLS(3), .WRAP(0)) dut_b (
    .clk25(clk25), .reset(reset), .x(x), .y(y), .active(active), .screenEnd(screenEnd),
    .buttons(buttons), .fsm_en(fsm_en), .color0(color0), .color1(color1),
    .VGA_R(rb), .VGA_G(gb), .VGA_B(bb), .sel(sel_b), .chc(chc_b), .chc_valid(cv_b)
  );

  vga_menu_grid #(.ROWS(1), .COLS(8)) dut_c (
    .clk25(clk25), .reset(reset), .x(x), .y(y), .active(active), .screenEnd(screenEnd),
    .buttons(buttons), .fsm_en(fsm_en), .color0(color0), .color1(color1),
    .VGA_R(rc), .VGA_G(gc), .VGA_B(bc), .sel(sel_c), .chc(chc_c), .chc_valid(cv_c)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    buttons = '0;
    screenEnd = 1'b0;
    fsm_en = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic press(input int b);
    buttons[b] = 1'b1;
    tick(3);
    buttons[b] = 1'b0;
    tick(3);
  endtask

  // One frame boundary; counts chc_valid cycles on dut_a afterwards.
  task automatic frame(output int pulses);
    pulses = 0;
    screenEnd = 1'b1;
    tick(1);
    screenEnd = 1'b0;
    if (cv_a) pulses++;
    repeat (4) begin
      tick(1);
      if (cv_a) pulses++;
    end
  endtask

  task automatic pix(input logic [9:0] xv, input logic [8:0] yv, input logic act);
    x = xv;
    y = yv;
    active = act;
    tick(2);
  endtask

  task automatic test_reset();
    int p, tot;
    do_reset();
    n_vec++; if (sel_a !== 2'd0) begin n_miss++; $display("FAIL reset_sel: got %0d want 0", sel_a); end
    n_vec++; if (chc_a !== 2'd0) begin n_miss++; $display("FAIL reset_chc: got %0d want 0", chc_a); end
    n_vec++; if (rgb_a !== 12'h000) begin n_miss++; $display("FAIL reset_rgb: got %h want 000", rgb_a); end
    tot = 0;
    repeat (3) begin frame(p); tot += p; end
    n_vec++; if (tot !== 0) begin n_miss++; $display("FAIL idle_valid: got %0d pulses want 0", tot); end
    pix(10'd40, 9'd196, 1'b1);
    n_vec++; if (rgb_a !== C1) begin n_miss++; $display("FAIL bar_cell0: got %h want %h", rgb_a, C1); end
    pix(10'd400, 9'd196, 1'b1);
    n_vec++; if (rgb_a !== C0) begin n_miss++; $display("FAIL bar_cell1: got %h want %h", rgb_a, C0); end
    pix(10'd292, 9'd48, 1'b1);
    n_vec++; if (rgb_a !== C1) begin n_miss++; $display("FAIL mark_cell0: got %h want %h", rgb_a, C1); end
    pix(10'd616, 9'd48, 1'b1);
    n_vec++; if (rgb_a !== C0) begin n_miss++; $display("FAIL mark_cell1: got %h want %h", rgb_a, C0); end
    pix(10'd40, 9'd196, 1'b0);
    n_vec++; if (rgb_a !== 12'h000) begin n_miss++; $display("FAIL blank: got %h want 000", rgb_a); end
  endtask

  task automatic test_latency();
    pix(10'd400, 9'd196, 1'b1);
    tick(1);
    x = 10'd40;
    tick(1);
    n_vec++; if (rgb_a !== C0) begin n_miss++; $display("FAIL lat_1cyc: got %h want %h", rgb_a, C0); end
    tick(1);
    n_vec++; if (rgb_a !== C1) begin n_miss++; $display("FAIL lat_2cyc: got %h want %h", rgb_a, C1); end
  endtask

  task automatic test_wrap();
    int p;
    do_reset();
    press(BTN_RIGHT);
    n_vec++; if (sel_a !== 2'd0) begin n_miss++; $display("FAIL wrap_early: got %0d want 0", sel_a); end
    frame(p);
    n_vec++; if (sel_a !== 2'd1) begin n_miss++; $display("FAIL wrap_r1: got %0d want 1", sel_a); end
    press(BTN_RIGHT); frame(p);
    n_vec++; if (sel_a !== 2'd0) begin n_miss++; $display("FAIL wrap_r2: got %0d want 0", sel_a); end
    press(BTN_DOWN); frame(p);
    n_vec++; if (sel_a !== 2'd2) begin n_miss++; $display("FAIL wrap_down: got %0d want 2", sel_a); end
    pix(10'd40, 9'd350, 1'b1);
    n_vec++; if (rgb_a !== C1) begin n_miss++; $display("FAIL bar_cell2: got %h want %h", rgb_a, C1); end
    pix(10'd40, 9'd196, 1'b1);
    n_vec++; if (rgb_a !== C0) begin n_miss++; $display("FAIL bar_cell0_off: got %h want %h", rgb_a, C0); end
  endtask

  task automatic test_clamp();
    int p;
    do_reset();
    press(BTN_LEFT); frame(p);
    n_vec++; if (sel_b !== 4'd0) begin n_miss++; $display("FAIL clamp_left: got %0d want 0", sel_b); end
    press(BTN_UP); frame(p);
    n_vec++; if (sel_b !== 4'd0) begin n_miss++; $display("FAIL clamp_up: got %0d want 0", sel_b); end
    repeat (3) begin press(BTN_RIGHT); frame(p); end
    n_vec++; if (sel_b !== 4'd2) begin n_miss++; $display("FAIL clamp_right3: got %0d want 2", sel_b); end
    press(BTN_DOWN); frame(p);
    n_vec++; if (sel_b !== 4'd5) begin n_miss++; $display("FAIL clamp_down: got %0d want 5", sel_b); end
  endtask

  task automatic test_confirm();
    int p;
    do_reset();
    press(BTN_RIGHT); press(BTN_A); frame(p);
    n_vec++; if (sel_a !== 2'd0) begin n_miss++; $display("FAIL conf_sel: got %0d want 0", sel_a); end
    n_vec++; if (chc_a !== 2'd0) begin n_miss++; $display("FAIL conf_chc: got %0d want 0", chc_a); end
    n_vec++; if (p !== 1) begin n_miss++; $display("FAIL conf_pulse: got %0d cycles want 1", p); end
    press(BTN_RIGHT); frame(p);
    press(BTN_A); frame(p);
    n_vec++; if (chc_a !== 2'd1) begin n_miss++; $display("FAIL conf_chc1: got %0d want 1", chc_a); end
    n_vec++; if (p !== 1) begin n_miss++; $display("FAIL conf_pulse1: got %0d cycles want 1", p); end
    pix(10'd616, 9'd48, 1'b1);
    n_vec++; if (rgb_a !== C1) begin n_miss++; $display("FAIL mark_chc1: got %h want %h", rgb_a, C1); end
    pix(10'd292, 9'd48, 1'b1);
    n_vec++; if (rgb_a !== C0) begin n_miss++; $display("FAIL mark_chc0_off: got %h want %h", rgb_a, C0); end
  endtask

  task automatic test_repeat();
    int p;
    do_reset();
    buttons[BTN_RIGHT] = 1'b1;
    tick(3);
    for (int f = 1; f <= 32; f++) begin
      frame(p);
      if (f == 19) begin
        n_vec++; if (sel_c !== 3'd1) begin n_miss++; $display("FAIL rpt_f19: got %0d want 1", sel_c); end
      end
      if (f == 20) begin
        n_vec++; if (sel_c !== 3'd2) begin n_miss++; $display("FAIL rpt_f20: got %0d want 2", sel_c); end
      end
      if (f == 25) begin
        n_vec++; if (sel_c !== 3'd2) begin n_miss++; $display("FAIL rpt_f25: got %0d want 2", sel_c); end
      end
      if (f == 26) begin
        n_vec++; if (sel_c !== 3'd3) begin n_miss++; $display("FAIL rpt_f26: got %0d want 3", sel_c); end
      end
    end
    n_vec++; if (sel_c !== 3'd4) begin n_miss++; $display("FAIL rpt_f32: got %0d want 4", sel_c); end
    buttons = '0;
    tick(3);
  endtask

  task automatic test_fsm_en();
    int p;
    do_reset();
    fsm_en = 1'b0;
    press(BTN_RIGHT); frame(p);
    n_vec++; if (sel_a !== 2'd0) begin n_miss++; $display("FAIL en_off: got %0d want 0", sel_a); end
    fsm_en = 1'b1;
    frame(p);
    n_vec++; if (sel_a !== 2'd0) begin n_miss++; $display("FAIL en_dropped: got %0d want 0", sel_a); end
  endtask

  task automatic test_cancel();
    int p;
    do_reset();
    press(BTN_RIGHT); frame(p);
    press(BTN_DOWN); frame(p);
    n_vec++; if (sel_a !== 2'd3) begin n_miss++; $display("FAIL canc_pre: got %0d want 3", sel_a); end
    press(BTN_B); frame(p);
    n_vec++; if (sel_a !== 2'd0) begin n_miss++; $display("FAIL canc_sel: got %0d want 0", sel_a); end
    press(BTN_RIGHT); frame(p);
    press(BTN_A); press(BTN_B); frame(p);
    n_vec++; if (sel_a !== 2'd0) begin n_miss++; $display("FAIL canc_prio_sel: got %0d want 0", sel_a); end
    n_vec++; if (p !== 0) begin n_miss++; $display("FAIL canc_prio_pulse: got %0d want 0", p); end
  endtask

  task automatic test_reset_mid();
    int p;
    do_reset();
    press(BTN_RIGHT); frame(p);
    press(BTN_A);
    active = 1'b1;
    reset = 1'b1;
    #2;
    n_vec++; if (sel_a !== 2'd0) begin n_miss++; $display("FAIL async_sel: got %0d want 0", sel_a); end
    n_vec++; if (rgb_a !== 12'h000) begin n_miss++; $display("FAIL async_rgb: got %h want 000", rgb_a); end
    tick(2);
    reset = 1'b0;
    tick(1);
    frame(p);
    n_vec++; if (chc_a !== 2'd0) begin n_miss++; $display("FAIL mid_chc: got %0d want 0", chc_a); end
    n_vec++; if (p !== 0) begin n_miss++; $display("FAIL mid_pulse: got %0d want 0", p); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_clamp();
    test_confirm();
    test_repeat();
    test_fsm_en();
    test_cancel();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/vga_menu_grid.md
Name: vga_menu_grid

Overview:
- Parametrised successor of the 2x2 settings menu: draws an R x C grid of menu cells on the VGA stream, with a selection bar under the hovered cell and a marker on the committed choice.
- Controller edges move the cursor with optional wrap, auto-repeat and frame-aligned commit.
- Sits between VGATimingGenerator (x, y, active, screenEnd) and the VGA pins.
- Exports the committed choice index to the settings/colour logic.

Parameters:
- ROWS, 2, grid rows (1..8).
- COLS, 2, grid columns (1..8).
- SCALE_SHIFT, 2, pixel-to-cell-space shift (x_adj = x >> SCALE_SHIFT).
- ORIGIN_X, 4, left edge of cell (0,0) in scaled units.
- ORIGIN_Y, 11, top edge of cell (0,0) in scaled units.
- CELL_W, 71, cell width in scaled units.
- CELL_H, 39, cell height in scaled units.
- GAP_X, 10, horizontal gap between cells.
- GAP_Y, 0, vertical gap between cells.
- BAR_H, 2, selection bar height at the cell bottom.
- MARK, 3, side of the square choice marker at the cell top-right.
- WRAP, 1, 1 = wrap within row/column, 0 = clamp at edges.
- REPEAT_DELAY, 20, frames a direction must be held before the first auto-repeat.
- REPEAT_RATE, 6, frames between subsequent repeats.
- DEFAULT_CHOICE, 0, reset value of sel and chc.

Ports:
- clk25  in  1  25 MHz pixel clock, the only clock.
- reset  in  1  asynchronous, active-high.
- x  in  10  pixel column from the timing generator.
- y  in  9  pixel row.
- active  in  1  high while drawing visible pixels.
- screenEnd  in  1  one-cycle pulse between frames.
- buttons  in  8  level inputs: [0] up, [1] down, [2] left, [3] right, [4] A/confirm, [5] B/cancel, [7:6] unused.
- fsm_en  in  1  enables navigation.
- color0  in  12  background colour.
- color1  in  12  highlight colour.
- VGA_R, VGA_G, VGA_B  out  4 each  pixel colour.
- sel  out  IDX_W  hovered cell index, equal to row*COLS+col.
- chc  out  IDX_W  committed choice index.
- chc_valid  out  1  one-cycle pulse when chc is written.

Behaviour:
- IDX_W = max(1, $clog2(ROWS*COLS)).
- Reset values: sel = chc = DEFAULT_CHOICE, chc_valid = 0, RGB = 0, all counters and pending flags cleared.
- Input stage: buttons are registered once; a rising edge is the registered value high with the previous value low.
- Edges set sticky pending flags: dir (2-bit code plus valid), conf, canc. A later direction edge in the same frame overwrites the pending direction.
- Commit happens only on the cycle screenEnd = 1 while fsm_en = 1. Priority: canc (sel <= chc) > conf (chc <= sel, chc_valid = 1 on the next cycle) > dir (move). All pending flags clear on that cycle.
- Move rules:
  - right/left: col +/- 1; at an edge, col wraps to 0 or COLS-1 if WRAP, else holds.
  - up/down: same rule on row.
  - If ROWS = 1 or COLS = 1, the corresponding moves are no-ops.
- Auto-repeat: a 6-bit frame counter runs while exactly one direction is held, counted on screenEnd.
  - Counter reaching REPEAT_DELAY injects a pending dir.
  - After that, a pending dir is injected every REPEAT_RATE frames.
  - The counter clears on release, on a change of direction, or when fsm_en = 0.
- fsm_en = 0: pending flags clear each cycle, sel/chc hold, drawing continues.
- Reset asserted mid-frame: all state returns to reset values immediately; no chc_valid pulse is produced.
- Pixel path, stage 1: x_adj, y_adj and per-cell hit tests are registered.
  - Cell (r,c): L = ORIGIN_X + c*(CELL_W+GAP_X), T = ORIGIN_Y + r*(CELL_H+GAP_Y).
  - Bar hit: L <= x_adj < L+CELL_W and T+CELL_H-BAR_H <= y_adj < T+CELL_H.
  - Marker hit: L+CELL_W-MARK <= x_adj < L+CELL_W and T <= y_adj < T+MARK.
- Pixel path, stage 2: output colour is registered.
  - RGB = color1 if (bar hit for cell sel) or (marker hit for cell chc).
  - Otherwise RGB = color0.
  - RGB = 0 when the delayed active is low.
- Latency: RGB reflects x/y/active from 2 cycles earlier; active is delayed to match.
- sel/chc change only at frame boundaries, so there is no tearing.

Decomposition:
- Shared package vga_menu_pkg holds:
  - button bit indices (BTN_UP .. BTN_B);
  - direction encoding (DIR_UP = 0, DIR_DOWN = 1, DIR_LEFT = 2, DIR_RIGHT = 3);
  - index-width helper function.
- One sub-module, menu_nav_fsm: edge detect, pending flags, repeat counter, sel/chc registers.
- Cell geometry and hit testing stay in the top module, using a generate loop over ROWS*COLS.

Test Plan:
- Reset then 3 frames idle -> sel = 0, chc = 0, chc_valid never high; the pixel at the bar of cell 0 is color1, the pixel at cell 1's bar is color0.
- 2x2, WRAP = 1: right pulse, then next screenEnd -> sel = 1; a second right -> sel = 0; down -> sel = 2.
- WRAP = 0, 3x3: left from sel = 0 -> sel stays 0; right x3 over 3 frames -> sel = 2.
- Right then A in the same frame, sel starting at 0 -> at screenEnd sel = 0 and chc = 0 (confirm wins); chc_valid is pulsed for exactly 1 cycle.
- Hold right for 32 frames, REPEAT_DELAY = 20, REPEAT_RATE = 6, COLS = 8, ROWS = 1 -> moves at frames 1, 20, 26, 32, so sel = 4.
- B after moving sel from 0 to 3 with chc = 0 -> sel = 0. Assert reset mid-frame with a pending A -> chc = DEFAULT_CHOICE and no chc_valid pulse.
